// File: rtl/btn_pkg.sv
// Shared types and constants for the button debouncer and related front-end inputs.
// Optional build macro used by btn_debounce: BTN_DEBOUNCE_INVERT_EN.
package btn_pkg;

  // Debounce FSM states: two settled levels plus one qualifying state for each direction.
  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    WAIT_HI   = 2'b01,
    STABLE_HI = 2'b10,
    WAIT_LO   = 2'b11
  } db_state_t;

  // 10 ms at 100 MHz.
  localparam int DB_STABLE_CYCLES_DEFAULT = 1000000;
  localparam int DB_CNT_WIDTH_DEFAULT     = 20;
  // Short qualification window used by simulation builds.
  localparam int DB_STABLE_CYCLES_SIM     = 4;

  // Debounced level that belongs to a state: high while settled high or qualifying a release.
  function automatic logic db_level_of(input db_state_t st);
    return (st == STABLE_HI) || (st == WAIT_LO);
  endfunction

  // A state is busy while a candidate transition is being qualified.
  function automatic logic db_busy_of(input db_state_t st);
    return (st == WAIT_HI) || (st == WAIT_LO);
  endfunction

endpackage

// File: rtl/btn_debounce_if.sv
// Signal bundle between a raw button pin, its debouncer and downstream logic.
// There is no valid/ready handshake here: btn_in is a free-running asynchronous
// pin sampled every cycle, and level/busy are registered levels that are
// meaningful on every cycle (level feeds an edge detector, not a transaction).
// dbg_state/dbg_cnt expose the debouncer's FSM state and stability counter.
interface btn_debounce_if #(
  parameter int CNT_WIDTH = btn_pkg::DB_CNT_WIDTH_DEFAULT
);
  import btn_pkg::*;

  logic                 btn_in;
  logic                 level;
  logic                 busy;
  db_state_t            dbg_state;
  logic [CNT_WIDTH-1:0] dbg_cnt;

  // Button/consumer side: drives the pin, observes the conditioned outputs.
  modport master (
    output btn_in,
    input  level,
    input  busy,
    input  dbg_state,
    input  dbg_cnt
  );

  // Debouncer side.
  modport slave (
    input  btn_in,
    output level,
    output busy,
    output dbg_state,
    output dbg_cnt
  );

endinterface

// File: rtl/sync_2ff.sv
// One-bit two-flop synchroniser for asynchronous inputs; both flops clear on reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_s1;
  logic r_s;

  // Two-stage capture of the asynchronous input into the clk domain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1 <= 1'b0;
      r_s  <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s  <= r_s1;
    end
  end

  assign o_q = r_s;

endmodule

// File: rtl/btn_debounce.sv
// Debouncer for one raw pushbutton: synchronise, then require STABLE_CYCLES
// consecutive samples at the new value before the registered level changes.
// Build option: define BTN_DEBOUNCE_INVERT_EN for active-low buttons with a
// pull-up; level=1 still means "pressed".
module btn_debounce #(
  parameter int STABLE_CYCLES = btn_pkg::DB_STABLE_CYCLES_DEFAULT,
  parameter int CNT_WIDTH     = btn_pkg::DB_CNT_WIDTH_DEFAULT
) (
  input logic           clk,
  input logic           rst,
  btn_debounce_if.slave bus
);
  import btn_pkg::*;

  // Terminal count: the sample that completes qualification is the one seen at this count.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic                 w_pin;
  logic                 w_s;
  db_state_t            r_state;
  db_state_t            w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic                 r_level;
  logic                 r_busy;

`ifdef BTN_DEBOUNCE_INVERT_EN
  assign w_pin = ~bus.btn_in;
`else
  assign w_pin = bus.btn_in;
`endif

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (w_pin),
    .o_q (w_s)
  );

  // Next-state and counter: a sample disagreeing with the settled level starts a
  // qualification run; any sample back at the settled level abandons it.
  always_comb begin
    w_state_nxt = STABLE_LO;
    w_cnt_nxt   = '0;
    case (r_state)
      STABLE_LO: begin
        if (w_s) begin
          w_state_nxt = WAIT_HI;
          w_cnt_nxt   = CNT_ONE;
        end else begin
          w_state_nxt = STABLE_LO;
        end
      end
      WAIT_HI: begin
        if (!w_s) begin
          w_state_nxt = STABLE_LO;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = STABLE_HI;
        end else begin
          w_state_nxt = WAIT_HI;
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!w_s) begin
          w_state_nxt = WAIT_LO;
          w_cnt_nxt   = CNT_ONE;
        end else begin
          w_state_nxt = STABLE_HI;
        end
      end
      WAIT_LO: begin
        if (w_s) begin
          w_state_nxt = STABLE_HI;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = STABLE_LO;
        end else begin
          w_state_nxt = WAIT_LO;
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = STABLE_LO;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State, counter and registered outputs; level/busy are decoded from the next
  // state so they line up with the state register on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= STABLE_LO;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= db_level_of(w_state_nxt);
      r_busy  <= db_busy_of(w_state_nxt);
    end
  end

  assign bus.level     = r_level;
  assign bus.busy      = r_busy;
  assign bus.dbg_state = r_state;
  assign bus.dbg_cnt   = r_cnt;

endmodule
